i2c_readback_fifo: RTL and testbench

- Sits directly downstream of i2c_controller.
- Captures each read result the controller emits (tag, data byte, NAK flag, one-cycle valid strobe) into a first-word-fall-through FIFO.
- Presents the entries to a consumer (host register interface, UART bridge) over a valid/ready stream.
- Keeps saturating statistics for dropped results and NAKed transfers.

---
 rtl/i2c_readback_fifo.sv | 115 +++++++++++
 tb/tb_i2c_readback_fifo.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/i2c_readback_fifo.sv
// Readback FIFO behind i2c_controller: captures {nak, tag, data} results into a
// first-word-fall-through queue and keeps saturating drop/NAK statistics.
module i2c_readback_fifo #(
  parameter int DEPTH    = 16,
  parameter bit DROP_NAK = 1'b0,
  parameter int STAT_W   = 16
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [11:0]                read_tag_i,
  input  logic [7:0]                 read_data_i,
  input  logic                       nak_i,
  input  logic                       read_data_valid_i,
  input  logic                       flush_i,
  input  logic                       clear_stats_i,
  output logic [11:0]                m_tag_o,
  output logic [7:0]                 m_data_o,
  output logic                       m_nak_o,
  output logic                       m_valid_o,
  input  logic                       m_ready_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [STAT_W-1:0]          overflow_count_o,
  output logic [STAT_W-1:0]          nak_count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int EW = 21;

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] count_reg, count_next;
  logic [EW-1:0] head_reg, head_next;
  logic [EW-1:0] in_entry;
  logic          push_req, push_ok, pop;

  assign in_entry  = {nak_i, read_tag_i, read_data_i};
  assign m_valid_o = (count_reg != '0);
  assign full_o    = (count_reg == CW'(DEPTH));
  assign empty_o   = (count_reg == '0);
  assign count_o   = count_reg;
  assign {m_nak_o, m_tag_o, m_data_o} = head_reg;

  assign push_req = read_data_valid_i & ~(DROP_NAK & nak_i);
  assign pop      = m_valid_o & m_ready_i;
  assign push_ok  = push_req & (~full_o | pop) & ~flush_i;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    head_next   = head_reg;
    if (flush_i) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      wr_ptr_next = wr_ptr_reg + AW'(push_ok);
      rd_ptr_next = rd_ptr_reg + AW'(pop);
      count_next  = count_reg + CW'(push_ok) - CW'(pop);
      // Head register is the registered RAM read; bypass the incoming entry
      // when the queue is (or is about to be) empty so it shows next cycle.
      if (count_next != '0) begin
        if (count_reg == CW'(pop))
          head_next = in_entry;
        else
          head_next = mem[rd_ptr_next];
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      head_reg   <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      head_reg   <= head_next;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok)
      mem[wr_ptr_reg] <= in_entry;
  end

  // Statistic 0 counts overflow drops, statistic 1 counts NAKed results.
  logic [1:0]        stat_inc;
  logic [STAT_W-1:0] stat_reg [2];

  assign stat_inc[0] = push_req & full_o & ~pop & ~flush_i;
  assign stat_inc[1] = read_data_valid_i & nak_i;

  for (genvar gi = 0; gi < 2; gi++) begin : g_stat
    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i)
        stat_reg[gi] <= '0;
      else if (clear_stats_i)
        stat_reg[gi] <= '0;
      else if (stat_inc[gi] && (stat_reg[gi] != {STAT_W{1'b1}}))
        stat_reg[gi] <= stat_reg[gi] + STAT_W'(1);
    end
  end

  assign overflow_count_o = stat_reg[0];
  assign nak_count_o      = stat_reg[1];

endmodule

// File: tb/tb_i2c_readback_fifo.sv
// Bench for i2c_readback_fifo: two configurations share stimulus; each has a
// queue-based reference model and a negedge monitor acting as scoreboard.
module tb_i2c_readback_fifo;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic [11:0] read_tag_i = '0;
  logic [7:0]  read_data_i = '0;
  logic        nak_i = 1'b0;
  logic        read_data_valid_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        clear_stats_i = 1'b0;
  logic        m_ready_i = 1'b0;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk_i = ~clk_i;

  task automatic chk(input int inst, input string nm, input longint act, input longint exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("[TB] FAIL dut%0d %s actual=%0h expected=%0h at %0t", inst, nm, act, exp, $time);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam int D    = (gi == 0) ? 16 : 4;
    localparam bit DROP = (gi == 0) ? 1'b0 : 1'b1;
    localparam int SW   = (gi == 0) ? 16 : 3;
    localparam int CW   = $clog2(D+1);
    localparam longint SMAX = (64'd1 << SW) - 1;

    logic [11:0]   m_tag;
    logic [7:0]    m_data;
    logic          m_nak, m_valid, full, empty;
    logic [CW-1:0] count;
    logic [SW-1:0] ovf_cnt, nak_cnt;

    i2c_readback_fifo #(.DEPTH(D), .DROP_NAK(DROP), .STAT_W(SW)) u_dut (
      .clk_i(clk_i), .reset_i(reset_i),
      .read_tag_i(read_tag_i), .read_data_i(read_data_i), .nak_i(nak_i),
      .read_data_valid_i(read_data_valid_i), .flush_i(flush_i),
      .clear_stats_i(clear_stats_i),
      .m_tag_o(m_tag), .m_data_o(m_data), .m_nak_o(m_nak), .m_valid_o(m_valid),
      .m_ready_i(m_ready_i), .count_o(count), .full_o(full), .empty_o(empty),
      .overflow_count_o(ovf_cnt), .nak_count_o(nak_cnt)
    );

    // Reference model: a bounded queue of {nak, tag, data} plus two counters.
    logic [20:0] q[$];
    longint      ovf_m = 0;
    longint      nak_m = 0;

    always @(posedge reset_i) begin
      q.delete();
      ovf_m = 0;
      nak_m = 0;
    end

    // Monitor already removed the entry popped at this edge, so q.size() < D
    // here means the push fits (either not full, or full with a pop).
    always @(posedge clk_i) begin
      if (!reset_i) begin
        bit preq;
        preq = read_data_valid_i && !(DROP && nak_i);
        if (clear_stats_i) begin
          ovf_m = 0;
          nak_m = 0;
        end else begin
          if (read_data_valid_i && nak_i && nak_m < SMAX) nak_m++;
          if (preq && !flush_i && q.size() >= D && ovf_m < SMAX) ovf_m++;
        end
        if (flush_i) q.delete();
        else if (preq && q.size() < D) q.push_back({nak_i, read_tag_i, read_data_i});
      end
    end

    always @(negedge clk_i) begin
      if (!reset_i) begin
        chk(gi, "count", longint'(count), longint'(q.size()));
        chk(gi, "full", longint'(full), longint'(q.size() == D));
        chk(gi, "empty", longint'(empty), longint'(q.size() == 0));
        chk(gi, "valid", longint'(m_valid), longint'(q.size() != 0));
        chk(gi, "overflow_count", longint'(ovf_cnt), ovf_m);
        chk(gi, "nak_count", longint'(nak_cnt), nak_m);
        if (m_valid && q.size() != 0) begin
          chk(gi, "head", longint'({m_nak, m_tag, m_data}), longint'(q[0]));
          if (m_ready_i) begin
            $display("[TB] dut%0d pop tag=%03h data=%02h nak=%0d", gi, m_tag, m_data, m_nak);
            void'(q.pop_front());
          end
        end
      end
    end
  end

  task automatic cyc(input bit v, input logic [11:0] t, input logic [7:0] d,
                     input bit n, input bit rdy, input bit fl, input bit cs);
    read_data_valid_i = v;
    read_tag_i        = t;
    read_data_i       = d;
    nak_i             = n;
    m_ready_i         = rdy;
    flush_i           = fl;
    clear_stats_i     = cs;
    @(posedge clk_i);
    #2;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cyc(1'b0, 12'h0, 8'h0, 1'b0, rdy, 1'b0, 1'b0);
  endtask

  task automatic check_reset_outputs();
    chk(0, "rst_valid", longint'(g_dut[0].m_valid), 0);
    chk(0, "rst_count", longint'(g_dut[0].count), 0);
    chk(0, "rst_empty", longint'(g_dut[0].empty), 1);
    chk(0, "rst_full", longint'(g_dut[0].full), 0);
    chk(0, "rst_head", longint'({g_dut[0].m_nak, g_dut[0].m_tag, g_dut[0].m_data}), 0);
    chk(0, "rst_ovf", longint'(g_dut[0].ovf_cnt), 0);
    chk(0, "rst_nak", longint'(g_dut[0].nak_cnt), 0);
    chk(1, "rst_valid", longint'(g_dut[1].m_valid), 0);
    chk(1, "rst_count", longint'(g_dut[1].count), 0);
    chk(1, "rst_ovf", longint'(g_dut[1].ovf_cnt), 0);
    chk(1, "rst_nak", longint'(g_dut[1].nak_cnt), 0);
  endtask

  initial begin
    #1;
    check_reset_outputs();
    repeat (3) @(posedge clk_i);
    #2;
    reset_i = 1'b0;
    idle(2, 1'b0);

    // In-order capture with consumer stalled, then drained.
    cyc(1'b1, 12'h001, 8'hA0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 12'h002, 8'hA1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 12'h003, 8'hA2, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(3, 1'b0);
    idle(5, 1'b1);

    // Overfill, then a push alongside a pop while full.
    for (int i = 0; i < 18; i++)
      cyc(1'b1, 12'(i), 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 12'h055, 8'h55, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(20, 1'b1);

    // NAK handling: dropped by the DROP_NAK instance, kept by the other.
    cyc(1'b1, 12'h010, 8'h10, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 12'h011, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2, 1'b0);
    idle(4, 1'b1);

    // Flush with a simultaneous push and pop, then clear_stats against a NAK.
    for (int i = 0; i < 5; i++)
      cyc(1'b1, 12'h100 + 12'(i), 8'hC0 + 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 12'h1FF, 8'hEE, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(2, 1'b1);
    cyc(1'b1, 12'h200, 8'h33, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(3, 1'b1);

    // Randomized traffic; the small instance saturates its 3-bit counters.
    for (int i = 0; i < 3000; i++)
      cyc(($urandom_range(0, 9) < 6), 12'($urandom), 8'($urandom),
          ($urandom_range(0, 9) < 3), ($urandom_range(0, 1) == 1),
          ($urandom_range(0, 49) == 0), ($urandom_range(0, 99) == 0));

    // Asynchronous reset mid-drain, checked before the next clock edge.
    idle(2, 1'b0);
    for (int i = 0; i < 8; i++)
      cyc(1'b1, 12'h300 + 12'(i), 8'h70 + 8'(i), 1'b1, 1'b0, 1'b0, 1'b0);
    idle(2, 1'b1);
    #1;
    reset_i = 1'b1;
    #1;
    check_reset_outputs();
    @(posedge clk_i);
    #2;
    reset_i = 1'b0;
    idle(3, 1'b1);
    cyc(1'b1, 12'h3AB, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(3, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
